// File: rtl/sobel_line_buf.sv
// sobel_line_buf: stores the previous M_DEPTH-1 lines and emits vertically aligned pixel columns
// with sync signals delayed by one cycle; unfilled rows and over-width columns read as zero.
module sobel_line_buf #(
    parameter int COLORDEPTH = 8,
    parameter int M_DEPTH    = 3,
    parameter int MAX_WIDTH  = 1280,
    parameter int ADDR_W     = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [COLORDEPTH-1:0] px_i,
    input  logic                  dv_i,
    input  logic                  hs_i,
    input  logic                  vs_i,
    output logic [COLORDEPTH-1:0] vect_o [M_DEPTH-1:0],
    output logic                  dv_o,
    output logic                  hs_o,
    output logic                  vs_o,
    output logic [1:0]            rows_valid_o,
    output logic                  ovf_o
);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(MAX_WIDTH);
    localparam logic [1:0]        SAT  = 2'(M_DEPTH - 1);

    logic [COLORDEPTH-1:0] mem [M_DEPTH-1][MAX_WIDTH];
    logic [COLORDEPTH-1:0] rd [M_DEPTH-1];
    logic [COLORDEPTH-1:0] px_q;
    logic [ADDR_W-1:0]     wr_col;
    logic [1:0]            line_cnt;
    logic [M_DEPTH-1:1]    mask_q;
    logic                  wr_en;
    logic                  line_end;

    assign wr_en        = dv_i && wr_col < LAST && !rst;
    assign line_end     = dv_o && !dv_i;
    assign rows_valid_o = line_cnt;

    // read-first cascade: each line memory takes the previous one's old data at this column
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[0][wr_col] <= px_i;
            for (int k = 1; k < M_DEPTH - 1; k++) mem[k][wr_col] <= mem[k-1][wr_col];
            for (int k = 0; k < M_DEPTH - 1; k++) rd[k] <= mem[k][wr_col];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_col   <= '0;
            line_cnt <= '0;
            ovf_o    <= 1'b0;
            dv_o     <= 1'b0;
            hs_o     <= 1'b0;
            vs_o     <= 1'b0;
            px_q     <= '0;
            mask_q   <= '0;
        end else begin
            dv_o     <= dv_i;
            hs_o     <= hs_i;
            vs_o     <= vs_i;
            px_q     <= dv_i ? px_i : '0;
            for (int k = 1; k < M_DEPTH; k++) mask_q[k] <= wr_en && k <= int'(line_cnt);
            wr_col   <= (vs_i || line_end) ? '0 : wr_col + ADDR_W'(wr_en);
            line_cnt <= vs_i ? '0 : line_cnt + 2'(line_end && line_cnt != SAT);
            ovf_o    <= !vs_i && (ovf_o || (dv_i && wr_col == LAST));
        end
    end

    always_comb begin
        vect_o[0] = px_q;
        for (int k = 1; k < M_DEPTH; k++) vect_o[k] = mask_q[k] ? rd[k-1] : '0;
    end
endmodule

// File: tb/tb_sobel_line_buf.sv
// tb_sobel_line_buf: directed checks of sobel_line_buf with a 16-pixel line limit.
module tb_sobel_line_buf;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] px  = '0;
    logic       dv  = 1'b0;
    logic       hs  = 1'b0;
    logic       vs  = 1'b0;
    logic [7:0] vect [2:0];
    logic       dv_o, hs_o, vs_o, ovf_o;
    logic [1:0] rows;
    int         n_vec = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    sobel_line_buf #(.COLORDEPTH(8), .M_DEPTH(3), .MAX_WIDTH(16), .ADDR_W(5)) dut (
        .clk(clk), .rst(rst), .px_i(px), .dv_i(dv), .hs_i(hs), .vs_i(vs),
        .vect_o(vect), .dv_o(dv_o), .hs_o(hs_o), .vs_o(vs_o),
        .rows_valid_o(rows), .ovf_o(ovf_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_vec(input string tag, input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2);
        chk({tag, ".v0"}, vect[0], e0);
        chk({tag, ".v1"}, vect[1], e1);
        chk({tag, ".v2"}, vect[2], e2);
    endtask

    // inputs applied at negedge; outputs for those inputs are visible 1 ns after the next posedge
    task automatic step(input logic [7:0] p, input logic d, input logic h, input logic v);
        @(negedge clk);
        px = p; dv = d; hs = h; vs = v;
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [7:0] base, input int w);
        for (int c = 0; c < w; c++) step(base + 8'(c), 1'b1, 1'b0, 1'b0);
        step(8'h00, 1'b0, 1'b0, 1'b0);
        step(8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        repeat (3) step(8'h00, 1'b0, 1'b0, 1'b0);
        chk_vec("rst", 8'h00, 8'h00, 8'h00);
        chk("rst.dv", dv_o, 0);
        chk("rst.rows", rows, 0);
        chk("rst.ovf", ovf_o, 0);
        rst = 1'b0;

        step(8'h00, 1'b0, 1'b0, 1'b1);
        chk("frm.vs_hi", vs_o, 1);
        step(8'h00, 1'b0, 1'b0, 1'b0);
        chk("frm.vs_lo", vs_o, 0);
        for (int l = 0; l < 4; l++) begin
            for (int c = 0; c < 8; c++) begin
                step(8'(16 * l + c), 1'b1, 1'b0, 1'b0);
                chk_vec("frm", 8'(16 * l + c), l >= 1 ? 8'(16 * (l - 1) + c) : 8'h00,
                        l >= 2 ? 8'(16 * (l - 2) + c) : 8'h00);
                chk("frm.dv", dv_o, 1);
            end
            step(8'h00, 1'b0, 1'b1, 1'b0);
            chk("gap.hs_hi", hs_o, 1);
            chk("gap.dv", dv_o, 0);
            chk("gap.v0", vect[0], 0);
            chk("gap.rows", rows, l >= 1 ? 2 : l + 1);
            step(8'h00, 1'b0, 1'b0, 1'b0);
            chk("gap.hs_lo", hs_o, 0);
        end

        step(8'h00, 1'b0, 1'b0, 1'b1);
        chk("vs.rows", rows, 0);
        chk("vs.vs_o", vs_o, 1);
        for (int c = 0; c < 8; c++) begin
            step(8'hA0 + 8'(c), 1'b1, 1'b0, 1'b0);
            chk_vec("stale", 8'hA0 + 8'(c), 8'h00, 8'h00);
        end
        step(8'h00, 1'b0, 1'b0, 1'b0);
        step(8'h00, 1'b0, 1'b0, 1'b0);

        step(8'h00, 1'b0, 1'b0, 1'b1);
        feed(8'h40, 8);
        feed(8'h50, 4);
        for (int c = 0; c < 8; c++) begin
            step(8'h60 + 8'(c), 1'b1, 1'b0, 1'b0);
            if (c < 4) chk_vec("var.head", 8'h60 + 8'(c), 8'h50 + 8'(c), 8'h40 + 8'(c));
            else chk_vec("var.tail", 8'h60 + 8'(c), 8'h40 + 8'(c), 8'hA0 + 8'(c));
        end
        step(8'h00, 1'b0, 1'b0, 1'b0);
        step(8'h00, 1'b0, 1'b0, 1'b0);

        step(8'h00, 1'b0, 1'b0, 1'b1);
        feed(8'h00, 16);
        feed(8'h20, 16);
        for (int c = 0; c < 18; c++) begin
            step(8'h40 + 8'(c), 1'b1, 1'b0, 1'b0);
            if (c < 16) chk_vec("ovf.in", 8'h40 + 8'(c), 8'h20 + 8'(c), 8'(c));
            else chk_vec("ovf.out", 8'h40 + 8'(c), 8'h00, 8'h00);
            chk("ovf.flag", ovf_o, c >= 16);
        end
        feed(8'h60, 4);
        chk("ovf.held", ovf_o, 1);
        step(8'h00, 1'b0, 1'b0, 1'b1);
        chk("ovf.vs_clr", ovf_o, 0);
        chk("ovf.vs_rows", rows, 0);
        step(8'h00, 1'b0, 1'b0, 1'b0);

        feed(8'h10, 8);
        feed(8'h20, 8);
        for (int c = 0; c < 5; c++) step(8'h30 + 8'(c), 1'b1, 1'b0, 1'b0);
        chk("mid.rows", rows, 2);
        rst = 1'b1;
        step(8'h35, 1'b1, 1'b1, 1'b1);
        chk_vec("mid.rst", 8'h00, 8'h00, 8'h00);
        chk("mid.dv", dv_o, 0);
        chk("mid.hs", hs_o, 0);
        chk("mid.vs", vs_o, 0);
        chk("mid.rows0", rows, 0);
        chk("mid.ovf", ovf_o, 0);
        rst = 1'b0;
        step(8'h00, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 8; c++) begin
            step(8'h70 + 8'(c), 1'b1, 1'b0, 1'b0);
            chk_vec("post", 8'h70 + 8'(c), 8'h00, 8'h00);
        end
        step(8'h00, 1'b0, 1'b0, 1'b0);
        chk("post.rows", rows, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/sobel_line_buf.md
Name: sobel_line_buf

Overview:
- Upstream neighbour of the Sobel convolution stage in the HDMI pipeline.
- Accepts a raster grayscale pixel stream with dv/hs/vs and stores the previous M_DEPTH-1 lines in on-chip line memories.
- Each cycle it emits a vertical column of M_DEPTH vertically aligned pixels plus sync signals delayed to match.
- Rows not yet filled at the top of a frame, and columns beyond MAX_WIDTH, are masked to zero.

Parameters:
- COLORDEPTH, 8, bits per pixel.
- M_DEPTH, 3, rows per output column; number of line memories = M_DEPTH-1.
- MAX_WIDTH, 1280, maximum pixels per line stored.
- ADDR_W, 11, column address width; requires 2**ADDR_W > MAX_WIDTH.

Ports:
- clk, input, 1, pixel clock.
- rst, input, 1, synchronous active-high reset.
- px_i, input, COLORDEPTH, input pixel, valid when dv_i=1.
- dv_i, input, 1, data valid.
- hs_i, input, 1, hsync.
- vs_i, input, 1, vsync.
- vect_o, output, COLORDEPTH x [M_DEPTH-1:0] unpacked, column vector. [0] = current line, [k] = k lines earlier.
- dv_o, output, 1, dv_i delayed 1 cycle.
- hs_o, output, 1, hs_i delayed 1 cycle.
- vs_o, output, 1, vs_i delayed 1 cycle.
- rows_valid_o, output, 2, completed lines since last vsync, saturating at M_DEPTH-1.
- ovf_o, output, 1, sticky: a line exceeded MAX_WIDTH.

Behaviour:
- Reset: rst is synchronous, active-high, clock clk.
  - All outputs, wr_col, line_cnt, ovf and the sync delay registers go to 0.
  - Memory contents are not cleared; stale data is hidden by line_cnt=0 masking.
- Latency: exactly 1 cycle from px_i/dv_i/hs_i/vs_i to vect_o/dv_o/hs_o/vs_o, for all paths.
- Memories: M_DEPTH-1 arrays of MAX_WIDTH x COLORDEPTH.
  - Synchronous read.
  - Read-first on same-address read/write; old data is returned.
- Column pointer wr_col:
  - Increments on every dv_i=1 cycle while wr_col<MAX_WIDTH.
  - Clears to 0 on the cycle after a dv_i 1->0 transition (line end).
  - Held at 0 while vs_i=1.
- Per cycle with dv_i=1 and wr_col<MAX_WIDTH, with a = wr_col:
  - Read mem[k][a] for all k.
  - Write mem[0][a] <= px_i.
  - Write mem[k][a] <= old mem[k-1][a] for k>=1, i.e. a cascade shift using read-first data.
- Output vect_o registered:
  - vect_o[0] = px_i.
  - vect_o[k] = mem[k-1][a] if k <= line_cnt, else 0.
  - All elements are 0 when dv_i=0.
- line_cnt (= rows_valid_o):
  - Increments by 1 on each line end, saturating at M_DEPTH-1.
  - Cleared while vs_i=1.
  - Line end and vs_i in the same cycle: vs_i wins, line_cnt=0.
- Overflow: dv_i=1 with wr_col==MAX_WIDTH.
  - No memory write.
  - vect_o[0]=px_i, vect_o[k>=1]=0.
  - ovf_o set the next cycle and held until vs_i=1 or rst.
- Short lines: a line shorter than the previous one reads only its own columns. Tail columns of longer earlier lines are left untouched in memory.
- Mid-line dv_i gap: treated as a line end (pointer clears, line_cnt increments). The upstream timing generator guarantees contiguous dv_i per line.
- rst mid-frame: takes effect the next cycle. The first line after rst is treated as frame top (vect_o[k>=1]=0).

Test Plan:
- Reset: rst asserted mid-line at col 5 of line 2 -> next cycle vect_o all 0, dv_o=hs_o=vs_o=0, rows_valid_o=0, ovf_o=0.
- Frame, 4 lines x 8 px, px=16*line+col:
  - line 0 -> vect_o={0,0,px}.
  - line 1, col 3 -> vect_o[0]=0x13, [1]=0x03, [2]=0.
  - line 2, col 3, one cycle after input -> vect_o[0]=0x23, [1]=0x13, [2]=0x03.
  - rows_valid_o steps 0->1->2 and holds at 2.
- vs_i pulse between frames with memories full -> rows_valid_o=0; first line of the new frame gives vect_o[1]=vect_o[2]=0 despite stale memory.
- Overflow, MAX_WIDTH=16, ADDR_W=5 in tb, line of 18 px after 2 full lines:
  - px 17,18 give vect_o[1..2]=0.
  - ovf_o=1 from the cycle after px 17, stays 1 across the next line, clears on vs_i.
- Sync alignment: single-cycle hs_i pulse and vs_i pulse at arbitrary points -> hs_o/vs_o identical pulses exactly 1 cycle later. dv_o tracks dv_i with 1-cycle delay across line boundaries.
- Variable widths: line of 8 px then line of 4 px then line of 8 px -> on the third line, cols 0-3 give vect_o[1]=line-1 data and vect_o[2]=line-0 data. Cols 4-7 give vect_o[1]=line-0 data (untouched tail) and vect_o[2]=stale/reset-era memory content, masked only by line_cnt.
